id_ex_pipe_reg: RTL

Parametrised ID→EX pipeline register with a valid/ready handshake, stall back-pressure, flush-to-bubble and an optional skid entry. It sits between the decode stage and the execute stage. It replaces the fixed-width free-running ID/EX latch with one that can hold, kill and buffer instructions. It captures on the falling edge of `Clk`, like the rest of the pipeline registers.

---
 rtl/id_ex_pipe_reg.sv | 127 ++++++++++++
 1 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with valid/ready handshake, stall hold, flush-to-bubble
// and an optional skid entry. All state updates on the falling edge of Clk.
module id_ex_pipe_reg #(
  parameter int PC_W    = 32,
  parameter int DATA_W  = 32,
  parameter int FUNC_W  = 6,
  parameter int IMM_W   = 16,
  parameter int REG_W   = 5,
  parameter bit SKID_EN = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   PC4,
  input  logic [PC_W-1:0]   Jtarg,
  input  logic [DATA_W-1:0] busA,
  input  logic [DATA_W-1:0] busB,
  input  logic [FUNC_W-1:0] func,
  input  logic [IMM_W-1:0]  immd,
  input  logic [REG_W-1:0]  Rd,
  input  logic [REG_W-1:0]  Rt,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [PC_W-1:0]   E_PC4,
  output logic [PC_W-1:0]   E_Jtarg,
  output logic [DATA_W-1:0] E_busA,
  output logic [DATA_W-1:0] E_busB,
  output logic [FUNC_W-1:0] E_func,
  output logic [IMM_W-1:0]  E_immd,
  output logic [REG_W-1:0]  E_Rd,
  output logic [REG_W-1:0]  E_Rt,
  output logic [1:0]        occ
);

  localparam int PL_W = 2*PC_W + 2*DATA_W + FUNC_W + IMM_W + 2*REG_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PL_W-1:0]   r_main;
  logic [PL_W-1:0]   r_skid;
  logic              r_init;
  logic [PL_W-1:0]   w_in_pl;
  logic              w_rdy;
  logic              w_acc;
  logic              w_iss;
  logic              w_load_in;
  logic              w_load_skid;
  logic              w_fill_skid;

  assign w_in_pl   = {PC4, Jtarg, busA, busB, func, immd, Rd, Rt};
  assign {E_PC4, E_Jtarg, E_busA, E_busB, E_func, E_immd, E_Rd, E_Rt} = r_main;
  assign out_valid = (r_state != ST_EMPTY);
  assign occ       = r_state;
  assign in_ready  = w_rdy;
  assign w_acc     = in_valid & w_rdy;
  assign w_iss     = out_valid & out_ready;

  // r_init keeps in_ready low until the first falling edge after Reset drops.
  always_comb begin
    if (SKID_EN) w_rdy = r_init & (r_state != ST_SKID);
    else         w_rdy = r_init & (~out_valid | out_ready);
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    w_state_nxt = r_state;
    w_load_in   = 1'b0;
    w_load_skid = 1'b0;
    w_fill_skid = 1'b0;
    unique case (r_state)
      ST_EMPTY: if (w_acc) begin
        w_state_nxt = ST_FULL;
        w_load_in   = 1'b1;
      end
      ST_FULL: begin
        if (w_acc && w_iss) begin
          w_load_in   = 1'b1;
        end else if (w_acc) begin
          w_state_nxt = ST_SKID;
          w_fill_skid = 1'b1;
        end else if (w_iss) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_SKID: if (w_iss) begin
        w_state_nxt = ST_FULL;
        w_load_skid = 1'b1;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_load_in   = 1'b0;
      w_load_skid = 1'b0;
      w_fill_skid = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(negedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_EMPTY;
      r_init  <= 1'b0;
      r_main  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_init  <= 1'b1;
      if (flush)            r_main <= '0;
      else if (w_load_in)   r_main <= w_in_pl;
      else if (w_load_skid) r_main <= r_skid;
    end
  end

  // NOTE: the skid payload is not reset; its validity is carried entirely by r_state.
  always_ff @(negedge Clk) begin
    if (w_fill_skid) r_skid <= w_in_pl;
  end

endmodule
